md5_msg_builder: RTL
====================

MD5_MSG_BUILDER -- requirements
Module: md5_msg_builder

Interface
REQ-001 Parameter WORD_BITS, default 32, MD5 word width; output block is 16*WORD_BITS bits.
REQ-002 Parameter MAX_KEY_BYTES, default 16, key storage depth in bytes.
REQ-003 Parameter MAX_DIGITS, default 9, maximum decimal digits of the nonce.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 key_valid  input  1  key byte strobe.
REQ-007 key_byte  input  8  ASCII key byte.
REQ-008 key_last  input  1  marks final key byte, qualified by key_valid.
REQ-009 i_stop  input  1  downstream match found; halt generation.
REQ-010 o_valid  output  1  o_block/o_nonce hold a candidate.
REQ-011 o_ready  input  1  downstream accepts when o_valid & o_ready.
REQ-012 o_block  output  16*WORD_BITS  padded MD5 block, word k at bits [k*WORD_BITS +: WORD_BITS].
REQ-013 o_nonce  output  32  binary value of the nonce in o_block.
REQ-014 o_done  output  1  generation ended (stopped or exhausted).
REQ-015 o_exhausted  output  1  nonce space exhausted without stop.

Function
REQ-016 FSM states LOAD, BUILD, PRESENT, DONE; reset state LOAD.
REQ-017 LOAD: each key_valid cycle appends key_byte at index key_len, key_len increments; bytes beyond MAX_KEY_BYTES dropped, key_len saturates.
REQ-018 LOAD: key_valid & key_last -> BUILD next cycle; nonce initialised to decimal 1 (BCD, 1 digit).
REQ-019 key_valid ignored outside LOAD.
REQ-020 Message = key bytes, then nonce ASCII digits MSD first, no leading zeros; L = key_len + digit count.
REQ-021 Byte i of message placed in word i/4, bits [8*(i%4) +: 8] (MD5 little-endian).
REQ-022 Byte L = 0x80; bytes L+1..55 = 0x00; word 14 = L*8; word 15 = 0.
REQ-023 BUILD: registers o_block and o_nonce in one cycle -> PRESENT; o_valid low in BUILD.
REQ-024 PRESENT: o_valid high; o_block, o_nonce stable until handshake.
REQ-025 Handshake in PRESENT: nonce BCD-increments (carry adds digit, 9->10, 99->100) -> BUILD; o_valid low exactly one cycle between blocks.
REQ-026 Nonce increment uses BCD digit counter plus parallel 32-bit binary counter; both agree at all times.
REQ-027 Handshake of nonce 10^MAX_DIGITS - 1 -> DONE, o_exhausted=1.
REQ-028 i_stop sampled in BUILD or PRESENT -> DONE next cycle, o_valid low; if handshake same cycle, transfer completes, then DONE.
REQ-029 DONE: o_done=1, o_valid=0; terminal until reset; i_stop in LOAD ignored.
REQ-030 o_ready without o_valid has no effect.

Reset
REQ-031 reset low asynchronously forces: state LOAD, key_len 0, nonce 1, o_valid 0, o_block 0, o_nonce 0, o_done 0, o_exhausted 0.
REQ-032 Reset mid-PRESENT drops current block; key must be reloaded.
REQ-033 Release synchronous to clk; first key byte accepted on first edge after release.

Verification
REQ-034 Key "abcdef", o_ready=1 -> first block: word0=0x64636261, word1=0x80316665, words2..13=0, word14=0x00000038, word15=0, o_nonce=1, o_valid 2 cycles after key_last.
REQ-035 Nonce 9 -> 10 rollover, key "abcdef" -> word1=0x30316665, word2=0x00000080, word14=0x00000040, o_nonce=10.
REQ-036 o_ready low 5 cycles in PRESENT -> o_valid, o_block, o_nonce unchanged all 5 cycles; one handshake on o_ready rise; next nonce +1.
REQ-037 i_stop with o_valid & o_ready same cycle at nonce 42 -> 42 transferred, o_done=1 next cycle, no nonce 43 emitted.
REQ-038 MAX_DIGITS=2, o_ready=1 -> nonces 1..99 each emitted once, then o_done=1, o_exhausted=1.
REQ-039 Key of MAX_KEY_BYTES+3 bytes -> only first MAX_KEY_BYTES used, word14 = (MAX_KEY_BYTES+1)*8 for nonce 1; reset low mid-PRESENT -> o_valid=0 immediately.

Source files
------------

// File: rtl/md5_msg_builder.sv
// Builds padded single-block MD5 messages of key || decimal(nonce),
// stepping the nonce through 1..10^MAX_DIGITS-1 under valid/ready flow control.
module md5_msg_builder #(
    parameter int WORD_BITS     = 32,
    parameter int MAX_KEY_BYTES = 16,
    parameter int MAX_DIGITS    = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_valid,
    input  logic [7:0]              key_byte,
    input  logic                    key_last,
    input  logic                    i_stop,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [16*WORD_BITS-1:0] o_block,
    output logic [31:0]             o_nonce,
    output logic                    o_done,
    output logic                    o_exhausted
);

    localparam int KLW = $clog2(MAX_KEY_BYTES + 1);
    localparam int NDW = $clog2(MAX_DIGITS + 1);
    localparam int BW  = 16 * WORD_BITS;

    typedef enum logic [1:0] {LOAD, BUILD, PRESENT, DONE} state_t;

    state_t         state, state_nxt;
    logic [7:0]     key_mem [MAX_KEY_BYTES];
    logic [KLW-1:0] key_len;
    logic [3:0]     dig [MAX_DIGITS];
    logic [NDW-1:0] ndig;
    logic [31:0]    bin;

    logic [3:0]     dig_inc [MAX_DIGITS];
    logic [NDW-1:0] ndig_inc;
    logic           wrap;
    logic [7:0]     msg [56];
    logic [5:0]     msg_len;
    logic [BW-1:0]  blk;

    // Digits above ndig are zero, so a carry into them naturally grows the count
    always_comb begin
        logic carry;
        carry    = 1'b1;
        ndig_inc = ndig;
        for (int d = 0; d < MAX_DIGITS; d++) begin
            dig_inc[d] = dig[d];
            if (carry) begin
                if (d == int'(ndig))
                    ndig_inc = ndig + 1'b1;
                if (dig[d] == 4'd9) begin
                    dig_inc[d] = 4'd0;
                end else begin
                    dig_inc[d] = dig[d] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    always_comb begin
        for (int i = 0; i < 56; i++)
            msg[i] = 8'h00;
        msg_len = 6'(key_len) + 6'(ndig);
        for (int k = 0; k < MAX_KEY_BYTES; k++)
            if (k < int'(key_len))
                msg[k] = key_mem[k];
        for (int d = 0; d < MAX_DIGITS; d++)
            if (d < int'(ndig))
                msg[6'(int'(key_len) + int'(ndig) - 1 - d)] = {4'h3, dig[d]};
        msg[msg_len] = 8'h80;
        blk = '0;
        for (int i = 0; i < 56; i++)
            blk[(i/4)*WORD_BITS + 8*(i%4) +: 8] = msg[i];
        blk[14*WORD_BITS +: WORD_BITS] = WORD_BITS'({msg_len, 3'b000});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:    if (key_valid && key_last) state_nxt = BUILD;
            BUILD:   state_nxt = i_stop ? DONE : PRESENT;
            PRESENT: begin
                if (i_stop || (o_ready && wrap))
                    state_nxt = DONE;
                else if (o_ready)
                    state_nxt = BUILD;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = LOAD;
        endcase
    end

    assign o_valid = (state == PRESENT);
    assign o_done  = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_len     <= '0;
            ndig        <= NDW'(1);
            bin         <= 32'd1;
            o_block     <= '0;
            o_nonce     <= '0;
            o_exhausted <= 1'b0;
            for (int k = 0; k < MAX_KEY_BYTES; k++)
                key_mem[k] <= 8'h00;
            for (int d = 0; d < MAX_DIGITS; d++)
                dig[d] <= (d == 0) ? 4'd1 : 4'd0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (key_valid) begin
                        if (int'(key_len) < MAX_KEY_BYTES) begin
                            for (int k = 0; k < MAX_KEY_BYTES; k++)
                                if (k == int'(key_len))
                                    key_mem[k] <= key_byte;
                            key_len <= key_len + 1'b1;
                        end
                        if (key_last) begin
                            ndig <= NDW'(1);
                            bin  <= 32'd1;
                            for (int d = 0; d < MAX_DIGITS; d++)
                                dig[d] <= (d == 0) ? 4'd1 : 4'd0;
                        end
                    end
                end
                BUILD: begin
                    o_block <= blk;
                    o_nonce <= bin;
                end
                PRESENT: begin
                    if (o_ready) begin
                        if (wrap) begin
                            o_exhausted <= !i_stop;
                        end else begin
                            dig  <= dig_inc;
                            ndig <= ndig_inc;
                            bin  <= bin + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
